// File: rtl/si_header_parser.sv
// AXI-Stream header parser: validates the 128-bit header (magic/version), tracks sequence numbers,
// strips the header and forwards payload beats of valid packets through a two-entry skid stage.
module si_header_parser #(
  parameter int          DATA_WIDTH     = 128,
  parameter int          KEEP_WIDTH     = (DATA_WIDTH + 7) / 8,
  parameter logic [31:0] HEADER_MAGIC   = 32'h5349_5454,
  parameter logic [15:0] HEADER_VERSION = 16'h0001
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  invalid_packet,
  output logic                  lost_packet
);

  typedef enum logic [1:0] {
    ST_HEADER  = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DROP    = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 next_state_s;

  logic                   header_valid_s;
  logic                   hdr_accept_s;
  logic                   push_s;
  logic [31:0]            hdr_seq_s;

  logic [31:0]            expected_seq_r;
  logic                   seq_known_r;
  logic                   lost_packet_r;

  logic                   out_valid_r;
  logic [DATA_WIDTH-1:0]  out_data_r;
  logic [KEEP_WIDTH-1:0]  out_keep_r;
  logic                   out_last_r;

  logic                   skid_valid_r;
  logic [DATA_WIDTH-1:0]  skid_data_r;
  logic [KEEP_WIDTH-1:0]  skid_keep_r;
  logic                   skid_last_r;

  // A header-only packet (tlast on the header) is rejected even if its fields match.
  function automatic logic header_ok(
    input logic [DATA_WIDTH-1:0] data,
    input logic [KEEP_WIDTH-1:0] keep,
    input logic                  last
  );
    header_ok = (data[31:0] == HEADER_MAGIC) &&
                (data[47:32] == HEADER_VERSION) &&
                (keep == {KEEP_WIDTH{1'b1}}) &&
                !last;
  endfunction

  assign header_valid_s = header_ok(s_axis_tdata, s_axis_tkeep, s_axis_tlast);
  assign hdr_seq_s      = s_axis_tdata[95:64];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_HEADER;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode, input ready, reject flag and skid push strobe.
  always_comb begin
    next_state_s   = state_r;
    s_axis_tready  = 1'b1;
    invalid_packet = 1'b0;
    push_s         = 1'b0;
    hdr_accept_s   = 1'b0;
    case (state_r)
      ST_HEADER: begin
        s_axis_tready  = 1'b1;
        invalid_packet = s_axis_tvalid && !header_valid_s;
        if (s_axis_tvalid) begin
          if (header_valid_s) begin
            next_state_s = ST_PAYLOAD;
            hdr_accept_s = 1'b1;
          end else if (!s_axis_tlast) begin
            next_state_s = ST_DROP;
          end else begin
            next_state_s = ST_HEADER;
          end
        end else begin
          next_state_s = ST_HEADER;
        end
      end
      ST_PAYLOAD: begin
        s_axis_tready = !skid_valid_r;
        if (s_axis_tvalid && !skid_valid_r) begin
          push_s = 1'b1;
          if (s_axis_tlast) begin
            next_state_s = ST_HEADER;
          end else begin
            next_state_s = ST_PAYLOAD;
          end
        end else begin
          next_state_s = ST_PAYLOAD;
        end
      end
      ST_DROP: begin
        s_axis_tready  = 1'b1;
        invalid_packet = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          next_state_s = ST_HEADER;
        end else begin
          next_state_s = ST_DROP;
        end
      end
      default: begin
        next_state_s   = ST_HEADER;
        s_axis_tready  = 1'b1;
        invalid_packet = 1'b0;
      end
    endcase
  end

  // Sequence tracking; only accepted headers touch it, and the first one after reset never flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      expected_seq_r <= 32'd0;
      seq_known_r    <= 1'b0;
      lost_packet_r  <= 1'b0;
    end else begin
      lost_packet_r <= hdr_accept_s && seq_known_r && (hdr_seq_s != expected_seq_r);
      if (hdr_accept_s) begin
        expected_seq_r <= hdr_seq_s + 32'd1;
        seq_known_r    <= 1'b1;
      end
    end
  end

  // Skid stage: the output register refills from the skid entry first so order is preserved.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r  <= 1'b0;
      out_data_r   <= {DATA_WIDTH{1'b0}};
      out_keep_r   <= {KEEP_WIDTH{1'b0}};
      out_last_r   <= 1'b0;
      skid_valid_r <= 1'b0;
      skid_data_r  <= {DATA_WIDTH{1'b0}};
      skid_keep_r  <= {KEEP_WIDTH{1'b0}};
      skid_last_r  <= 1'b0;
    end else begin
      if (!out_valid_r || m_axis_tready) begin
        if (skid_valid_r) begin
          out_valid_r  <= 1'b1;
          out_data_r   <= skid_data_r;
          out_keep_r   <= skid_keep_r;
          out_last_r   <= skid_last_r;
          skid_valid_r <= 1'b0;
        end else if (push_s) begin
          out_valid_r <= 1'b1;
          out_data_r  <= s_axis_tdata;
          out_keep_r  <= s_axis_tkeep;
          out_last_r  <= s_axis_tlast;
        end else begin
          out_valid_r <= 1'b0;
        end
      end else if (push_s) begin
        skid_valid_r <= 1'b1;
        skid_data_r  <= s_axis_tdata;
        skid_keep_r  <= s_axis_tkeep;
        skid_last_r  <= s_axis_tlast;
      end
    end
  end

  assign m_axis_tvalid = out_valid_r;
  assign m_axis_tdata  = out_data_r;
  assign m_axis_tkeep  = out_keep_r;
  assign m_axis_tlast  = out_last_r;
  assign lost_packet   = lost_packet_r;

endmodule

// File: tb/tb_si_header_parser.sv
// Scoreboard bench for si_header_parser: expected payload beats are queued at input handshake
// and compared as the output handshakes; header checks and skid occupancy are checked inline.
module tb_si_header_parser;

  localparam int          DW    = 128;
  localparam int          KW    = 16;
  localparam logic [31:0] MAGIC = 32'h5349_5454;
  localparam logic [15:0] VER   = 16'h0001;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic          invalid_packet;
  logic          lost_packet;

  beat_t exp_q[$];
  int    tests_run   = 0;
  int    fails       = 0;
  int    pushed_cnt  = 0;
  int    popped_cnt  = 0;
  int    cyc         = 0;
  int    last_wait   = 0;
  logic  last_inv    = 1'b0;
  logic  rand_ready  = 1'b0;
  logic  ready_level = 1'b1;

  si_header_parser #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .HEADER_MAGIC(MAGIC), .HEADER_VERSION(VER)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .invalid_packet(invalid_packet), .lost_packet(lost_packet)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready driver: fixed level or random per cycle.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
    end
  end

  // Output monitor: every output handshake must match the head of the scoreboard.
  initial begin : monitor
    beat_t e;
    logic  hs;
    forever begin
      @(negedge clk);
      hs = m_axis_tvalid && m_axis_tready && !rst;
      if (hs) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL out_beat unexpected: data=%h keep=%h last=%b, none expected",
                   m_axis_tdata, m_axis_tkeep, m_axis_tlast);
        end else begin
          e = exp_q.pop_front();
          if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== e) begin
            fails++;
            $display("FAIL out_beat: got data=%h keep=%h last=%b, want data=%h keep=%h last=%b",
                     m_axis_tdata, m_axis_tkeep, m_axis_tlast, e.d, e.k, e.l);
          end
        end
      end
      @(posedge clk);
      if (hs) popped_cnt++;
    end
  end

  function automatic logic [DW-1:0] hdr(input logic [31:0] magic, input logic [15:0] ver,
                                        input logic [31:0] seq);
    hdr = {32'hA5A5_0000, seq, 16'h1234, ver, magic};
  endfunction

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                           input bit payload);
    logic exp_rdy;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    last_wait     = 0;
    forever begin
      @(negedge clk);
      last_inv = invalid_packet;
      if (payload) begin
        exp_rdy = ((pushed_cnt - popped_cnt) < 2);
        tests_run++;
        if (s_axis_tready !== exp_rdy) begin
          fails++;
          $display("FAIL s_tready_occupancy: got %b want %b (occupancy %0d)",
                   s_axis_tready, exp_rdy, pushed_cnt - popped_cnt);
        end
      end
      if (s_axis_tready) begin
        @(posedge clk);
        #1;
        if (payload) begin
          exp_q.push_back('{d: d, k: k, l: l});
          pushed_cnt++;
        end
        break;
      end
      @(posedge clk);
      #1;
      last_wait++;
      if (last_wait > 200) begin
        tests_run++;
        fails++;
        $display("FAIL beat_timeout: s_axis_tready stayed %b, want 1 within 200 cycles",
                 s_axis_tready);
        break;
      end
    end
  endtask

  task automatic idle();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_header(input logic [31:0] seq, input logic [31:0] magic,
                             input logic [KW-1:0] keep, input logic last,
                             input logic exp_inv, input logic exp_lost);
    send_beat(hdr(magic, VER, seq), keep, last, 1'b0);
    tests_run++;
    if (last_inv !== exp_inv) begin
      fails++;
      $display("FAIL hdr_invalid seq=%h: got %b want %b", seq, last_inv, exp_inv);
    end
    tests_run++;
    if (lost_packet !== exp_lost) begin
      fails++;
      $display("FAIL hdr_lost seq=%h: got %b want %b", seq, lost_packet, exp_lost);
    end
  endtask

  task automatic drain();
    int n = 0;
    idle();
    while ((exp_q.size() != 0 || m_axis_tvalid) && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d beats still expected, want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({m_axis_tvalid, m_axis_tlast, lost_packet, invalid_packet} !== 4'b0000 ||
        m_axis_tdata !== '0 || m_axis_tkeep !== '0 || s_axis_tready !== 1'b1) begin
      fails++;
      $display("FAIL reset_state: got mv=%b md=%h mk=%h ml=%b lost=%b inv=%b sr=%b, want all 0, sr=1",
               m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, lost_packet,
               invalid_packet, s_axis_tready);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [DW-1:0] d1, d2, d3;
    d1 = {4{32'h1111_0001}};
    d2 = {4{32'h2222_0002}};
    d3 = {4{32'h3333_0003}};
    send_header(32'd5, MAGIC, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    send_beat(d1, 16'hFFFF, 1'b0, 1'b1);
    tests_run++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== d1) begin
      fails++;
      $display("FAIL basic_latency: got valid=%b data=%h, want valid=1 data=%h",
               m_axis_tvalid, m_axis_tdata, d1);
    end
    send_beat(d2, 16'hFFFF, 1'b0, 1'b1);
    send_beat(d3, 16'h00FF, 1'b1, 1'b1);
    tests_run++;
    if (last_inv !== 1'b0 || lost_packet !== 1'b0) begin
      fails++;
      $display("FAIL basic_flags: got inv=%b lost=%b, want 0 0", last_inv, lost_packet);
    end
    drain();
  endtask

  task automatic test_sequence();
    logic [31:0] seqs [6] = '{32'd6, 32'd7, 32'd8, 32'd10, 32'hFFFF_FFFF, 32'h0000_0000};
    logic        lost [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      send_header(seqs[i], MAGIC, 16'hFFFF, 1'b0, 1'b0, lost[i]);
      send_beat({4{seqs[i]}}, 16'hFFFF, 1'b1, 1'b1);
      tests_run++;
      if (lost_packet !== 1'b0) begin
        fails++;
        $display("FAIL lost_width seq=%h: got %b one cycle later, want 0", seqs[i], lost_packet);
      end
    end
    drain();
  endtask

  task automatic test_bad_magic();
    send_header(32'd1, 32'hDEAD_BEEF, 16'hFFFF, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send_beat({4{32'hBAD0_0000 + 32'(i)}}, 16'hFFFF, (i == 2), 1'b0);
      tests_run++;
      if (last_inv !== 1'b1 || last_wait != 0) begin
        fails++;
        $display("FAIL drop_beat%0d: got inv=%b waits=%0d, want inv=1 waits=0", i, last_inv, last_wait);
      end
    end
    send_header(32'd1, MAGIC, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    send_beat({4{32'hC0DE_0001}}, 16'hFFFF, 1'b0, 1'b1);
    send_beat({4{32'hC0DE_0002}}, 16'h0FFF, 1'b1, 1'b1);
    drain();
  endtask

  task automatic test_header_only();
    send_header(32'd50, MAGIC, 16'hFFFF, 1'b1, 1'b1, 1'b0);
    send_header(32'd60, MAGIC, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    send_header(32'd2, MAGIC, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    send_beat({4{32'h0E0E_0E0E}}, 16'hFFFF, 1'b1, 1'b1);
    drain();
  endtask

  task automatic test_random_ready();
    send_header(32'd3, MAGIC, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    rand_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send_beat({$urandom, $urandom, $urandom, 32'(i)}, 16'($urandom), (i == 15), 1'b1);
    end
    rand_ready = 1'b0;
    drain();
  endtask

  task automatic test_back_to_back();
    int start;
    int waits = 0;
    start = cyc;
    for (int p = 0; p < 2; p++) begin
      send_header(32'd4 + 32'(p), MAGIC, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      waits += last_wait;
      send_beat({4{32'hB2B0_0000 + 32'(p)}}, 16'hFFFF, 1'b0, 1'b1);
      waits += last_wait;
      send_beat({4{32'hB2B1_0000 + 32'(p)}}, 16'hFFFF, 1'b1, 1'b1);
      waits += last_wait;
    end
    tests_run++;
    if (cyc - start != 6 || waits != 0) begin
      fails++;
      $display("FAIL back_to_back: got %0d cycles %0d waits, want 6 cycles 0 waits",
               cyc - start, waits);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    ready_level = 1'b0;
    @(posedge clk);
    #1;
    send_header(32'd6, MAGIC, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    send_beat({4{32'h7777_0001}}, 16'hFFFF, 1'b0, 1'b1);
    send_beat({4{32'h7777_0002}}, 16'hFFFF, 1'b0, 1'b1);
    idle();
    rst = 1'b1;
    #1;
    tests_run++;
    if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1 || lost_packet !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: got mv=%b sr=%b lost=%b, want 0 1 0",
               m_axis_tvalid, s_axis_tready, lost_packet);
    end
    exp_q.delete();
    pushed_cnt = 0;
    popped_cnt = 0;
    ready_level = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_header(32'h1234_0000, MAGIC, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    send_beat({4{32'h8888_0001}}, 16'hFFFF, 1'b1, 1'b1);
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sequence();
    test_bad_magic();
    test_header_only();
    test_random_ready();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
